tl_phase_scheduler: RTL and testbench

//   Decides which phase the intersection serves next and for how long. Samples sensor,

---
 rtl/tl_phase_if.sv | 29 ++
 rtl/tl_phase_scheduler.sv | 178 +++++++++++++++++
 tb/tb_tl_phase_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tl_phase_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tl_phase_if                                                |
// | Purpose  : Phase-command channel between the phase scheduler and the  |
// |            light sequencer (valid/ready command plus done pulse).     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
interface tl_phase_if #(
  parameter int CW = 8
);
  logic          cmd_valid;
  logic [2:0]    cmd_phase;
  logic [CW-1:0] cmd_time;
  logic          cmd_ready;
  logic          phase_done;

  // Scheduler side: offers commands, receives acceptance and completion.
  modport master (
    output cmd_valid, cmd_phase, cmd_time,
    input  cmd_ready, phase_done
  );

  // Sequencer side: accepts commands, reports completion.
  modport slave (
    input  cmd_valid, cmd_phase, cmd_time,
    output cmd_ready, phase_done
  );
endinterface
`default_nettype wire

// File: rtl/tl_phase_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tl_phase_scheduler                                         |
// | Purpose  : Chooses the next intersection phase and its duration and   |
// |            issues it to the light sequencer; handles pedestrian,      |
// |            transit, emergency and accident priorities.                |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tl_phase_scheduler #(
  parameter int CW         = 8,
  parameter int MIN_GREEN  = 20,
  parameter int EXT_STEP   = 10,
  parameter int MAX_GREEN  = 100,
  parameter int PED_TIME   = 20,
  parameter int CLEAR_TIME = 10
) (
  input  wire        clk,
  input  wire        reset,
  input  wire        accident,
  input  wire        emerg_a,
  input  wire        emerg_b,
  input  wire        ped_req_a,
  input  wire        ped_req_b,
  input  wire        veh_a,
  input  wire        veh_b,
  input  wire        transit_a,
  input  wire        transit_b,
  output logic [1:0] ped_pending,
  output logic       busy,
  tl_phase_if.master cmd
);

  localparam logic [2:0] P_ALL_RED = 3'd0;
  localparam logic [2:0] P_SERVE_A = 3'd1;
  localparam logic [2:0] P_SERVE_B = 3'd2;
  localparam logic [2:0] P_PED     = 3'd3;
  localparam logic [2:0] P_EMERG_A = 3'd4;
  localparam logic [2:0] P_EMERG_B = 3'd5;
  localparam logic [2:0] P_FLASH   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          issue_valid;
  logic [2:0]    issue_phase;
  logic [CW-1:0] issue_time;
  logic          last_served;   // 0 = approach A, 1 = approach B
  logic [2:0]    last_phase;    // last phase that actually transferred

  logic          dem_a;
  logic          dem_b;
  logic          serve_b;
  logic          serve_veh;
  logic          serve_transit;
  logic [CW:0]   green_sum;
  logic [CW-1:0] green_time;
  logic          last_vehicle;
  logic [2:0]    sel_phase;
  logic [CW-1:0] sel_time;
  logic          sel_priority;
  logic          preempt;
  logic          release_hit;
  logic          xfer;

  assign cmd.cmd_valid = issue_valid;
  assign cmd.cmd_phase = issue_phase;
  assign cmd.cmd_time  = issue_time;

  // Next-phase selection, green-time computation and preemption/release detection.
  always_comb begin
    dem_a         = veh_a | transit_a;
    dem_b         = veh_b | transit_b;
    // Prefer the other approach when it has demand, then the same one, else the other.
    serve_b       = last_served ? (!dem_a && dem_b) : (dem_b || !dem_a);
    serve_veh     = serve_b ? veh_b : veh_a;
    serve_transit = serve_b ? transit_b : transit_a;
    green_sum     = (CW+1)'(MIN_GREEN)
                  + (serve_veh     ? (CW+1)'(EXT_STEP) : '0)
                  + (serve_transit ? (CW+1)'(EXT_STEP) : '0);
    green_time    = (green_sum > (CW+1)'(MAX_GREEN)) ? CW'(MAX_GREEN) : green_sum[CW-1:0];
    last_vehicle  = (last_phase == P_SERVE_A) || (last_phase == P_SERVE_B);

    sel_priority  = 1'b1;
    sel_time      = '0;
    if (accident) begin
      sel_phase = P_FLASH;
    end else if (emerg_a) begin
      sel_phase = P_EMERG_A;
    end else if (emerg_b) begin
      sel_phase = P_EMERG_B;
    end else if ((ped_pending != 2'b00) && last_vehicle) begin
      sel_phase    = P_PED;
      sel_time     = CW'(PED_TIME);
      sel_priority = 1'b0;
    end else begin
      sel_phase    = serve_b ? P_SERVE_B : P_SERVE_A;
      sel_time     = green_time;
      sel_priority = 1'b0;
    end

    // A higher-priority request that differs from what is running cuts the phase short.
    preempt     = sel_priority && (sel_phase != issue_phase);
    release_hit = ((issue_phase == P_EMERG_A) && !emerg_a)
               || ((issue_phase == P_EMERG_B) && !emerg_b)
               || ((issue_phase == P_FLASH)   && !accident);
    xfer        = issue_valid && cmd.cmd_ready;
  end

  // Command FSM: load payload, hold it through the handshake, then wait or preempt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      issue_valid <= 1'b0;
      issue_phase <= P_ALL_RED;
      issue_time  <= '0;
      busy        <= 1'b0;
      last_served <= 1'b1;
      last_phase  <= P_ALL_RED;
    end else begin
      case (state)
        S_IDLE: begin
          issue_phase <= sel_phase;
          issue_time  <= sel_time;
          issue_valid <= 1'b1;
          busy        <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (xfer) begin
            issue_valid <= 1'b0;
            last_phase  <= issue_phase;
            if (issue_phase == P_SERVE_A) last_served <= 1'b0;
            if (issue_phase == P_SERVE_B) last_served <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (preempt) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (release_hit) begin
            // Clearance interval; the released emergency approach counts as just served.
            issue_phase <= P_ALL_RED;
            issue_time  <= CW'(CLEAR_TIME);
            issue_valid <= 1'b1;
            if (issue_phase == P_EMERG_A) last_served <= 1'b0;
            if (issue_phase == P_EMERG_B) last_served <= 1'b1;
            state       <= S_ISSUE;
          end else if (cmd.phase_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          issue_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Pedestrian request latch; cleared when the PED command transfers, new presses win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending <= 2'b00;
    end else begin
      ped_pending <= ((xfer && (issue_phase == P_PED)) ? 2'b00 : ped_pending)
                   | {ped_req_b, ped_req_a};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_phase_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_tl_phase_scheduler                                      |
// | Purpose  : Directed self-checking bench for tl_phase_scheduler; a     |
// |            second instance with MAX_GREEN=30 checks saturation.       |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_tl_phase_scheduler;
  localparam int CW = 8;
  localparam logic [2:0] P_ALL_RED = 3'd0;
  localparam logic [2:0] P_SERVE_A = 3'd1;
  localparam logic [2:0] P_SERVE_B = 3'd2;
  localparam logic [2:0] P_PED     = 3'd3;
  localparam logic [2:0] P_EMERG_B = 3'd5;
  localparam logic [2:0] P_FLASH   = 3'd6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic accident = 1'b0, emerg_a = 1'b0, emerg_b = 1'b0;
  logic ped_req_a = 1'b0, ped_req_b = 1'b0;
  logic veh_a = 1'b0, veh_b = 1'b0, transit_a = 1'b0, transit_b = 1'b0;
  logic cmd_ready = 1'b1, phase_done = 1'b0;
  logic [1:0] ped_pending, ped_pending_sat;
  logic busy, busy_sat;
  int n_checks = 0;
  int n_fail = 0;

  tl_phase_if #(.CW(CW)) bus ();
  tl_phase_if #(.CW(CW)) bus_sat ();
  assign bus.cmd_ready      = cmd_ready;
  assign bus.phase_done     = phase_done;
  assign bus_sat.cmd_ready  = cmd_ready;
  assign bus_sat.phase_done = phase_done;

  tl_phase_scheduler #(.CW(CW)) dut (
    .clk(clk), .reset(reset), .accident(accident), .emerg_a(emerg_a), .emerg_b(emerg_b),
    .ped_req_a(ped_req_a), .ped_req_b(ped_req_b), .veh_a(veh_a), .veh_b(veh_b),
    .transit_a(transit_a), .transit_b(transit_b), .ped_pending(ped_pending),
    .busy(busy), .cmd(bus)
  );

  tl_phase_scheduler #(.CW(CW), .MAX_GREEN(30)) dut_sat (
    .clk(clk), .reset(reset), .accident(accident), .emerg_a(emerg_a), .emerg_b(emerg_b),
    .ped_req_a(ped_req_a), .ped_req_b(ped_req_b), .veh_a(veh_a), .veh_b(veh_b),
    .transit_a(transit_a), .transit_b(transit_b), .ped_pending(ped_pending_sat),
    .busy(busy_sat), .cmd(bus_sat)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an offered command and checks its payload.
  task automatic wait_cmd(input string tag, input logic [2:0] ph, input logic [CW-1:0] tm);
    int n;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, 32'(bus.cmd_valid), 32'd1);
    check_val({tag, "_phase"}, 32'(bus.cmd_phase), 32'(ph));
    check_val({tag, "_time"},  32'(bus.cmd_time),  32'(tm));
  endtask

  // Pulses phase_done while the scheduler sits in S_WAIT.
  task automatic finish_phase();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  // Lets the offered command transfer, then ends its phase.
  task automatic done_pulse();
    tick();
    finish_phase();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_val("rst_valid", 32'(bus.cmd_valid), 32'd0);
    check_val("rst_phase", 32'(bus.cmd_phase), 32'd0);
    check_val("rst_time",  32'(bus.cmd_time),  32'd0);
    check_val("rst_ped",   32'(ped_pending),   32'd0);
    check_val("rst_busy",  32'(busy),          32'd0);
    reset = 1'b0;

    // 1: idle alternation starting with A
    wait_cmd("t1_a", P_SERVE_A, 8'd20);
    check_val("t1_busy", 32'(busy), 32'd1);
    done_pulse();
    wait_cmd("t1_b", P_SERVE_B, 8'd20);
    done_pulse();
    wait_cmd("t1_a2", P_SERVE_A, 8'd20);

    // 2: vehicle + transit extension on B, and saturation in the MAX_GREEN=30 instance
    tick();
    veh_b = 1'b1; transit_b = 1'b1;
    finish_phase();
    wait_cmd("t2_b", P_SERVE_B, 8'd40);
    check_val("t2_sat_time", 32'(bus_sat.cmd_time), 32'd30);
    veh_b = 1'b0; transit_b = 1'b0;
    done_pulse();

    // 3: pedestrian request served after a vehicle phase
    wait_cmd("t3_a", P_SERVE_A, 8'd20);
    tick();
    ped_req_a = 1'b1;
    tick();
    ped_req_a = 1'b0;
    check_val("t3_pending", 32'(ped_pending), 32'd1);
    finish_phase();
    wait_cmd("t3_ped", P_PED, 8'd20);
    check_val("t3_pending_hold", 32'(ped_pending), 32'd1);
    tick();
    check_val("t3_pending_clr", 32'(ped_pending), 32'd0);
    finish_phase();
    wait_cmd("t3_veh", P_SERVE_B, 8'd20);
    done_pulse();

    // 4: emergency preemption mid-phase, clearance, then resume
    wait_cmd("t4_a", P_SERVE_A, 8'd20);
    tick();
    emerg_b = 1'b1;
    wait_cmd("t4_emerg", P_EMERG_B, 8'd0);
    tick(); tick(); tick();
    check_val("t4_hold_busy", 32'(busy), 32'd1);
    emerg_b = 1'b0;
    wait_cmd("t4_clear", P_ALL_RED, 8'd10);
    done_pulse();
    wait_cmd("t4_resume", P_SERVE_A, 8'd20);

    // 5: backpressure keeps the payload stable
    tick();
    cmd_ready = 1'b0;
    finish_phase();
    wait_cmd("t5_b", P_SERVE_B, 8'd20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t5_hold_valid", 32'(bus.cmd_valid), 32'd1);
      check_val("t5_hold_phase", 32'(bus.cmd_phase), 32'(P_SERVE_B));
      check_val("t5_hold_time",  32'(bus.cmd_time),  32'd20);
    end
    cmd_ready = 1'b1;
    tick();
    check_val("t5_xfer_valid", 32'(bus.cmd_valid), 32'd0);
    check_val("t5_xfer_busy",  32'(busy),          32'd1);

    // 6: accident beats emergency; asynchronous reset during the handshake
    cmd_ready = 1'b0;
    accident  = 1'b1;
    emerg_a   = 1'b1;
    wait_cmd("t6_flash", P_FLASH, 8'd0);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", 32'(bus.cmd_valid),     32'd0);
    check_val("t6_rst_busy",  32'(busy),              32'd0);
    check_val("t6_rst_phase", 32'(bus.cmd_phase),     32'd0);
    check_val("t6_rst_sat",   32'(bus_sat.cmd_valid), 32'd0);
    tick();
    accident  = 1'b0;
    emerg_a   = 1'b0;
    cmd_ready = 1'b1;
    reset     = 1'b0;
    wait_cmd("t6_after", P_SERVE_A, 8'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
